uart_tx_ctrl: RTL
=================

# uart_tx_ctrl

Memory-mapped UART transmit controller between the CPU store path and the board `uart_tx` pin. The CPU pushes bytes through a one-cycle write strobe. Bytes are buffered in a small FIFO and serialised as 8N1 frames, LSB first, at a fixed baud rate derived from `sysclk`. Status outputs let software poll before writing, and a sticky flag records any dropped byte.

## Interface
- `CLK_HZ`, 100_000_000, `sysclk` frequency in Hz.
- `BAUD`, 115200, line rate; bit period `DIV = CLK_HZ / BAUD` cycles (integer divide, must be ≥ 2).
- `FIFO_DEPTH`, 16, byte entries; power of two.
- `sysclk`  in  1  system clock; all state on rising edge.
- `cpu_resetn`  in  1  reset, asynchronous, active-low. One clock, no other reset.
- `wr_en`  in  1  single-cycle write strobe from the CPU store decode.
- `wr_data`  in  8  byte to send; sampled when `wr_en` = 1.
- `ovf_clr`  in  1  clears `ovf`.
- `fifo_full`  out  1  registered; count == `FIFO_DEPTH`.
- `fifo_empty`  out  1  registered; count == 0.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte in flight.
- `tx_busy`  out  1  FSM not in IDLE.
- `ovf`  out  1  sticky: a write was dropped.
- `uart_tx`  out  1  serial line; idle high; registered output.

## Operation
- Reset values: `uart_tx` = 1, `fifo_count` = 0, `fifo_empty` = 1, `fifo_full` = 0, `tx_busy` = 0, `ovf` = 0, FSM = IDLE, baud counter = 0, bit index = 0.
- FIFO write:
  - `wr_en` with `fifo_full` = 0: the byte is enqueued.
  - `wr_en` with `fifo_full` = 1: the byte is dropped and `ovf` is set. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop: `fifo_count` is unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- `ovf`: set has priority over `ovf_clr` in the same cycle.
- FSM states:
  - IDLE: if `fifo_empty` = 0, pop the head into the shift register and go to START. Otherwise stay.
  - START: drive 0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[0]` for DIV cycles, then shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: drive 1 for DIV cycles. At the end, if `fifo_empty` = 0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..DIV-1 within each state. It resets to 0 on every state change.
- Reset asserted mid-frame: the frame is abandoned, `uart_tx` goes high asynchronously, and FIFO contents are discarded.

## Timing
- Write at edge N into an empty FIFO with the FSM in IDLE:
  - `fifo_empty` = 0 after edge N.
  - Pop and IDLE→START at edge N+1.
  - `uart_tx` falls after edge N+2 (registered output).
- Frame length is exactly 10·DIV cycles.
- Back-to-back frames: the stop bit of frame k is followed immediately by the start bit of frame k+1.
- `tx_busy` rises at the IDLE→START edge. It falls at the STOP→IDLE edge.
- Status outputs reflect the state after the most recent edge. There is no combinational path from `wr_en` to any output.

## Structure
- Shared header `uart_defs.vh`: FSM state encodings (IDLE, START, DATA, STOP, 2-bit) and the `DIV` localparam formula. The future RX block reuses it.
- One sub-module, `sync_fifo`:
  - Parameterised width 8 and depth `FIFO_DEPTH`.
  - Push/pop, registered full/empty/count, drop-on-full.
- `uart_tx_ctrl` contains the FSM, baud counter, shift register and `ovf` logic.

## Test plan
All scenarios use `CLK_HZ` = 1_000_000, `BAUD` = 100_000 (DIV = 10), `FIFO_DEPTH` = 16.
- **Reset:** hold `cpu_resetn` = 0 for 5 cycles → `uart_tx` = 1, `fifo_count` = 0, `fifo_empty` = 1, `tx_busy` = 0, `ovf` = 0.
- **Single byte:** write 0x55 at edge N → `uart_tx` low from N+2 for 10 cycles, then 1,0,1,0,1,0,1,0 (10 cycles each), then high. `tx_busy` drops at edge N+101.
- **Back-to-back:** write 0x41, 0x42, 0x43 on consecutive cycles → 300 contiguous line cycles, no idle gap. Decoded bytes are 0x41, 0x42, 0x43; `tx_busy` stays 1 throughout.
- **Overflow:** write 18 bytes (0x00..0x11) on consecutive cycles:
  - `fifo_full` = 1 after the 17th write.
  - 0x11 is dropped and `ovf` = 1.
  - Exactly 17 frames (0x00..0x10) are transmitted.
- **Overflow clear:** `ovf_clr` pulse alone → `ovf` = 0. `ovf_clr` in the same cycle as a dropped write → `ovf` stays 1.
- **Reset mid-frame:** queue 0xA5 and 0x3C, then pull `cpu_resetn` low during data bit 3 of the first frame:
  - `uart_tx` goes to 1 asynchronously and `fifo_count` = 0.
  - After release, no frame is sent for 200 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: line FSM state encodings and the bit-period formula.
// The receive block is expected to import the same package.
package uart_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Bit period in sysclk cycles, integer divide; callers must keep the result >= 2.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// Byte FIFO with registered full/empty/count; a push while full is dropped.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_nxt;
  logic          push_ok, pop_ok;

  // Full/empty are registered, so drop-on-full holds even with a same-cycle pop.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// CPU-facing UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sysclk,
  input  logic                        cpu_resetn,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        ovf_clr,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_busy,
  output logic                        ovf,
  output logic                        uart_tx
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift, fifo_dout;
  logic        pop, bit_end, line_nxt;

  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sysclk),
    .rst_n (cpu_resetn),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end = (cnt == CW'(DIV - 1));
  assign tx_busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    line_nxt  = 1'b1;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = START;
      end
      START: begin
        line_nxt = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        line_nxt = shift[0];
        if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (bit_end) begin
        // Chain straight into the next start bit when more bytes are queued.
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state || state == IDLE || bit_end) cnt_nxt = '0;
    else                                                cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      uart_tx <= line_nxt;
      if (pop)                        shift <= fifo_dout;
      else if (state == DATA && bit_end) shift <= {1'b0, shift[7:1]};
      if (state == DATA && bit_end)   bit_idx <= bit_idx + 3'd1;
      else if (state != DATA)         bit_idx <= '0;
      if (wr_en && fifo_full)         ovf <= 1'b1;
      else if (ovf_clr)               ovf <= 1'b0;
    end
  end

endmodule
